// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state type.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU: operand request with
// valid/ready on one side, registered result with valid/ready on the other.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             in_c;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_c;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, op, in_c, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_s, out_c, zero, overflow
  );

  modport slave (
    input  in_valid, op, in_c, in_x, in_y, out_ready,
    output in_ready, out_valid, out_s, out_c, zero, overflow
  );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: ADD/SUB/AND/OR/XOR/SLT with carry and
// signed-overflow flags; the width-generic form of the old 4-bit ALU.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic             c_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  logic [WIDTH:0] sum;

  // NOTE: every output gets a default first, so no path through the case
  // leaves a value unassigned and infers a latch.
  always_comb begin
    sum      = '0;
    s        = '0;
    c_out    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
        s        = sum[WIDTH-1:0];
        c_out    = sum[WIDTH];
        overflow = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry-out of x + ~y + 1 is the inverted borrow.
        sum      = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        s        = sum[WIDTH-1:0];
        c_out    = sum[WIDTH];
        overflow = (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: s = x & y;
      OP_OR:  s = x | y;
      OP_XOR: s = x ^ y;
      OP_SLT: s = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: accepts one request at a time, runs single-cycle ops through
// alu_core and iterates SLL/MUL one bit per cycle, then holds the result.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  seq_alu_if.slave  bus
);

  state_t             state;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       cnt;
  logic [SHW-1:0]     shamt;

  logic [WIDTH-1:0]   core_s;
  logic               core_c;
  logic               core_v;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (bus.op),
    .c_in     (bus.in_c),
    .x        (bus.in_x),
    .y        (bus.in_y),
    .s        (core_s),
    .c_out    (core_c),
    .overflow (core_v)
  );

  assign shamt         = bus.in_y[SHW-1:0];
  assign acc_next      = mplier[0] ? acc + mcand : acc;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_ADD;
      mcand        <= '0;
      acc          <= '0;
      mplier       <= '0;
      cnt          <= '0;
      bus.out_s    <= '0;
      bus.out_c    <= 1'b0;
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q   <= bus.op;
          mcand  <= {{WIDTH{1'b0}}, bus.in_x};
          mplier <= bus.in_y;
          acc    <= '0;
          case (bus.op)
            OP_MUL: begin
              cnt   <= (SHW+1)'(WIDTH);
              state <= BUSY;
            end
            OP_SLL: begin
              if (shamt == '0) begin
                bus.out_s    <= bus.in_x;
                bus.out_c    <= 1'b0;
                bus.zero     <= (bus.in_x == '0);
                bus.overflow <= 1'b0;
                state        <= DONE;
              end else begin
                cnt   <= {1'b0, shamt};
                state <= BUSY;
              end
            end
            default: begin
              bus.out_s    <= core_s;
              bus.out_c    <= core_c;
              bus.zero     <= (core_s == '0);
              bus.overflow <= core_v;
              state        <= DONE;
            end
          endcase
        end

        // SLL and MUL share the left-shifting operand register; only MUL
        // consumes the accumulator and the right-shifting multiplier.
        BUSY: begin
          cnt    <= cnt - 1'b1;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= mplier >> 1;
          acc    <= acc_next;
          if (cnt == (SHW+1)'(1)) begin
            state        <= DONE;
            bus.overflow <= 1'b0;
            if (op_q == OP_MUL) begin
              bus.out_s <= acc_next[WIDTH-1:0];
              bus.out_c <= |acc_next[2*WIDTH-1:WIDTH];
              bus.zero  <= (acc_next[WIDTH-1:0] == '0);
            end else begin
              bus.out_s <= {mcand[WIDTH-2:0], 1'b0};
              bus.out_c <= mcand[WIDTH-1];
              bus.zero  <= (mcand[WIDTH-2:0] == '0);
            end
          end
        end

        DONE: if (bus.out_ready) state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vector table, handshake
// corner sequences, randomized ops and an ADD/SUB sweep against a behavioural model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W      = 8;
  localparam int SHW_TB = $clog2(W);
  localparam int MAX_S  = (1 << (W-1)) - 1;
  localparam int MIN_S  = -(1 << (W-1));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else
      n_pass++;
  endtask

  // Behavioural model: plain integer arithmetic on the operand values.
  function automatic res_t ref_model(input logic [2:0] op, input logic cin,
                                     input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    int ux, uy, sx, sy, t, sh;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    r.s = '0; r.c = 1'b0; r.v = 1'b0; r.lat = 1;
    case (op)
      OP_ADD: begin
        t   = ux + uy + int'(cin);
        r.s = W'(t);
        r.c = (t >= (1 << W));
        t   = sx + sy + int'(cin);
        r.v = (t > MAX_S) || (t < MIN_S);
      end
      OP_SUB: begin
        r.s = W'(ux - uy);
        r.c = (ux >= uy);
        t   = sx - sy;
        r.v = (t > MAX_S) || (t < MIN_S);
      end
      OP_AND: r.s = x & y;
      OP_OR:  r.s = x | y;
      OP_XOR: r.s = x ^ y;
      OP_SLT: r.s = (sx < sy) ? W'(1) : W'(0);
      OP_SLL: begin
        sh    = uy % (1 << SHW_TB);
        r.s   = W'(ux << sh);
        r.c   = (sh != 0) && (((ux >> (W - sh)) & 1) == 1);
        r.lat = 1 + sh;
      end
      default: begin
        t     = ux * uy;
        r.s   = W'(t);
        r.c   = (t >= (1 << W));
        r.lat = 1 + W;
      end
    endcase
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic compare(input string tag, input res_t got, input res_t exp);
    check({tag, "_s"},     32'(got.s), 32'(exp.s));
    check({tag, "_flags"}, {29'b0, got.c, got.z, got.v}, {29'b0, exp.c, exp.z, exp.v});
    check({tag, "_lat"},   got.lat, exp.lat);
  endtask

  // One full transaction: request, scramble inputs after accept, wait for
  // the result within a bounded number of cycles, then consume it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic cin,
                        input logic [W-1:0] x, input logic [W-1:0] y, output res_t got);
    int lat;
    bit busy_ok;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op; bus.in_c = cin; bus.in_x = x; bus.in_y = y;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op   = 3'($urandom);
    bus.in_c = 1'($urandom);
    bus.in_x = W'($urandom);
    bus.in_y = W'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (lat > 1) check({tag, "_busy_ready"}, 32'(busy_ok), 32'd1);
    got.s = bus.out_s; got.c = bus.out_c; got.z = bus.zero; got.v = bus.overflow;
    got.lat = lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_release"}, {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    vec_t vecs[$];
    res_t got, exp;

    bus.in_valid = 1'b0; bus.op = OP_ADD; bus.in_c = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.in_ready), 32'd1);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_outs",  {22'b0, bus.out_s, bus.out_c, bus.zero, bus.overflow}, 32'd0);
    rst = 1'b0;

    //            op      cin   x      y      s      c     z     v     lat
    vecs.push_back('{OP_ADD, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_SUB, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SUB, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_SLT, 1'b0, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLL, 1'b0, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{OP_SLL, 1'b0, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{OP_MUL, 1'b0, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{OP_ADD, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SLL, 1'b0, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_AND, 1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_OR,  1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_XOR, 1'b0, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SLT, 1'b0, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SLT, 1'b0, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_MUL, 1'b0, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 9});
    vecs.push_back('{OP_MUL, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 9});
    vecs.push_back('{OP_SUB, 1'b1, 8'h03, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLL, 1'b0, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8});
    vecs.push_back('{OP_SLL, 1'b0, 8'hFF, 8'h0F, 8'h80, 1'b1, 1'b0, 1'b0, 8});

    foreach (vecs[i]) begin
      exp.s = vecs[i].s; exp.c = vecs[i].c; exp.z = vecs[i].z; exp.v = vecs[i].v;
      exp.lat = vecs[i].lat;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].cin, vecs[i].x, vecs[i].y, got);
      compare($sformatf("vec%0d", i), got, exp);
    end

    // Backpressure: result held for 5 cycles while a new request waits.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.in_c = 1'b0; bus.in_x = 8'h7F; bus.in_y = 8'h01;
    @(negedge clk);
    bus.op = OP_MUL; bus.in_x = 8'h33; bus.in_y = 8'h44;
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k),
            {20'b0, bus.out_s, bus.out_c, bus.zero, bus.overflow, bus.out_valid, bus.in_ready},
            {20'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_not_taken", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op; logic cin; logic [W-1:0] x, y;
      op = 3'($urandom); cin = 1'($urandom); x = W'($urandom); y = W'($urandom);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, cin, x, y, got);
      compare($sformatf("rnd%0d_op%0d_x%0h_y%0h", i, op, x, y), got, ref_model(op, cin, x, y));
    end

    // Signed grid from -128 to 127 in steps of 5, both ends included.
    for (int xi = MIN_S; xi <= MAX_S; xi += 5) begin
      for (int yi = MIN_S; yi <= MAX_S; yi += 5) begin
        for (int k = 0; k < 2; k++) begin
          logic [2:0] op; logic cin;
          op  = (k == 0) ? OP_ADD : OP_SUB;
          cin = 1'((xi ^ yi) & 1);
          run_op("sweep", op, cin, W'(xi), W'(yi), got);
          compare($sformatf("sweep_op%0d_x%0d_y%0d", op, xi, yi), got,
                  ref_model(op, cin, W'(xi), W'(yi)));
        end
      end
    end

    // Reset during the third BUSY cycle of a MUL aborts it silently.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.in_c = 1'b0; bus.in_x = 8'h7B; bus.in_y = 8'hC5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", {30'b0, bus.out_valid, bus.in_ready}, 32'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
    check("abort_outs",  {22'b0, bus.out_s, bus.out_c, bus.zero, bus.overflow}, 32'd0);
    begin
      bit stray = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.out_valid) stray = 1'b1;
      end
      check("abort_no_output", 32'(stray), 32'd0);
    end

    run_op("post_reset_mul", OP_MUL, 1'b0, 8'h03, 8'h05, got);
    compare("post_reset_mul", got, ref_model(OP_MUL, 1'b0, 8'h03, 8'h05));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised-width successor to the team's 4-bit combinational ALU.
- Keeps its op set and carry/zero/overflow flags, and adds an iterative shift-left and an iterative unsigned multiply.
- Wraps all operations in a valid/ready handshake with registered results.
- Sits between the datapath register read stage and writeback; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 4.
- SHW, $clog2(WIDTH), width of the shift amount taken from in_y[SHW-1:0]; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  3  operation code.
- in_c  in  1  carry-in; used by ADD only.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y, or shift amount for SLL.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- out_s  out  WIDTH  result.
- out_c  out  1  carry flag.
- zero  out  1  out_s == 0.
- overflow  out  1  signed overflow flag.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_s=0; out_c=0; zero=0; overflow=0; all iteration counters and accumulators cleared.
- Reset mid-operation aborts the operation with no output, and the state reaches IDLE on the next edge.
- Accept: a request is accepted on a clk edge with in_valid && in_ready. op, in_c, in_x and in_y are latched; later input changes are ignored.
- in_ready=1 only in IDLE.
- States and transitions:
  - IDLE -> DONE for single-cycle ops.
  - IDLE -> BUSY for SLL with shamt != 0, and for MUL.
  - IDLE -> DONE for SLL with shamt == 0.
  - BUSY -> DONE when the iteration counter expires.
  - DONE -> IDLE on out_ready.
- out_valid=1 exactly in DONE. out_s and the flags are registered and held stable through DONE until out_ready.
- out_valid is never dropped without out_ready.
- Op encodings and results (zero = out_s==0 for every op):
  - 000 ADD: {c,s} = x+y+in_c, computed in WIDTH+1 bits. overflow = sign(x)==sign(y) && sign(s)!=sign(x).
  - 001 SUB: s = x+~y+1, in_c ignored. c = carry-out (1 means no borrow). overflow = sign(x)!=sign(y) && sign(s)!=sign(x).
  - 010 AND, 011 OR, 100 XOR: bitwise; c=0, overflow=0.
  - 101 SLT: s = ($signed(x) < $signed(y)) ? 1 : 0. Correct even when x-y overflows. c=0, overflow=0.
  - 110 SLL: shifts one bit per cycle for shamt = y[SHW-1:0] cycles. c = last bit shifted out of the MSB (0 if shamt=0). overflow=0.
  - 111 MUL: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles in BUSY. s = product[WIDTH-1:0]. c = |product[2*WIDTH-1:WIDTH]. overflow=0.
- Latency (accept edge to the first cycle out_valid=1):
  - 1 cycle for single-cycle ops and for SLL with shamt=0.
  - 1+shamt cycles for SLL.
  - 1+WIDTH cycles for MUL.
- Wrap-around: ADD and SUB wrap modulo 2^WIDTH. Upper bits of y beyond SHW are ignored for SLL.
- Simultaneous events:
  - in_valid while not IDLE is ignored; the requester must hold it.
  - out_ready while not in DONE has no effect.

Decomposition:
- Package seq_alu_pkg:
  - op encodings OP_ADD..OP_MUL (3-bit localparams).
  - state enum {IDLE, BUSY, DONE}.
- Sub-module alu_core: purely combinational, for ADD/SUB/AND/OR/XOR/SLT plus c/overflow. Parametrised by WIDTH; it is the generalised form of the existing ALU.
- The top level owns the FSM, the SLL/MUL iteration datapath and the result registers.

Test Plan (WIDTH=8):
- ADD x=0x7F, y=0x01, in_c=0 -> out_valid one cycle after accept; s=0x80, c=0, overflow=1, zero=0.
- SUB x=0x05, y=0x05 -> s=0x00, c=1, overflow=0, zero=1.
- SUB x=0x80, y=0x01 -> s=0x7F, c=1, overflow=1.
- SLT x=0x80 (-128), y=0x7F -> s=0x01.
- SLL x=0x81, y=0x03 -> out_valid exactly 4 cycles after accept; s=0x08, c=0.
- SLL x=0x81, y=0x01 -> s=0x02, c=1.
- MUL x=0x10, y=0x11 -> out_valid 9 cycles after accept; s=0x10, c=1, overflow=0. Check in_ready=0 during BUSY.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_s and flags stable and in_ready=0; a concurrent in_valid is not accepted. Raise out_ready -> IDLE next cycle.
- Exhaustive: sweep ADD/SUB over signed x,y in -128..127 against a reference model. Then assert rst at cycle 3 of a MUL -> out_valid=0, in_ready=1 the cycle after reset is released, and all outputs are 0.
